// File: rtl/popcount_arbiter.sv
// -----------------------------------------------------------------------------
// popcount_arbiter
//
// Round-robin arbiter in front of one shared bit-serial population counter.
// In IDLE, one requester is picked. Its word is loaded into a right-shift
// register A and counter B is cleared. In SHIFT, B accumulates A[0] until A
// is zero. DONE then pulses the served requester and publishes the count.
//
// Ports
//   clk      : single clock, rising-edge active
//   reset    : synchronous, active-high; wins over every other input
//   req      : [N]   request per requester
//   data_in  : [N*W] packed words, requester i owns [i*W +: W]
//   gnt      : [N]   registered one-hot grant, held from first SHIFT to DONE
//   busy     : registered, high whenever the FSM is not in IDLE
//   done     : [N]   registered one-cycle completion pulse, in the DONE cycle
//   result   : [CW]  registered popcount of the served word, held until the
//                    next DONE or reset
// -----------------------------------------------------------------------------
module popcount_arbiter #(
    parameter int W = 8,
    parameter int N = 4,
    localparam int CW = $clog2(W + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic [N*W-1:0]  data_in,
    output logic [N-1:0]    gnt,
    output logic            busy,
    output logic [N-1:0]    done,
    output logic [CW-1:0]   result
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [W-1:0]    a_r;
    logic [W-1:0]    a_next_s;
    logic [CW-1:0]   b_r;
    logic [CW-1:0]   b_next_s;
    logic [PW-1:0]   p_r;
    logic [PW-1:0]   p_next_s;
    logic [PW-1:0]   win_r;
    logic [PW-1:0]   win_next_s;
    logic [N-1:0]    gnt_next_s;
    logic [N-1:0]    done_next_s;
    logic [CW-1:0]   result_next_s;
    logic            busy_next_s;
    logic            found_s;
    logic [PW-1:0]   pick_s;

    // Round-robin search starting at pointer P, wrapping modulo N.
    always_comb begin
        int idx_v;
        found_s = 1'b0;
        pick_s  = p_r;
        idx_v   = 0;
        for (int off = 0; off < N; off++) begin
            idx_v = (int'(p_r) + off) % N;
            if (!found_s && req[idx_v]) begin
                found_s = 1'b1;
                pick_s  = PW'(idx_v);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state, datapath and output computation for the IDLE/SHIFT/DONE FSM.
    always_comb begin
        state_next_s  = state_r;
        a_next_s      = a_r;
        b_next_s      = b_r;
        p_next_s      = p_r;
        win_next_s    = win_r;
        gnt_next_s    = gnt;
        done_next_s   = {N{1'b0}};
        result_next_s = result;

        case (state_r)
            IDLE: begin
                gnt_next_s = {N{1'b0}};
                if (found_s) begin
                    state_next_s = SHIFT;
                    a_next_s     = data_in[pick_s*W +: W];
                    b_next_s     = {CW{1'b0}};
                    win_next_s   = pick_s;
                    gnt_next_s   = {{(N-1){1'b0}}, 1'b1} << pick_s;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (a_r != {W{1'b0}}) begin
                    // A count of at most W always fits in CW bits.
                    b_next_s = b_r + {{(CW-1){1'b0}}, a_r[0]};
                    a_next_s = a_r >> 1;
                end else begin
                    // Done/result are registered, so they are set on the way
                    // into DONE and become visible during the DONE cycle.
                    state_next_s  = DONE;
                    done_next_s   = {{(N-1){1'b0}}, 1'b1} << win_r;
                    result_next_s = b_r;
                    p_next_s      = (win_r == PW'(N - 1)) ? {PW{1'b0}}
                                                          : win_r + {{(PW-1){1'b0}}, 1'b1};
                end
            end
            DONE: begin
                state_next_s = IDLE;
                gnt_next_s   = {N{1'b0}};
            end
            default: begin
                state_next_s = IDLE;
                gnt_next_s   = {N{1'b0}};
            end
        endcase

        busy_next_s = (state_next_s != IDLE);
    end

    // State, datapath and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            a_r     <= {W{1'b0}};
            b_r     <= {CW{1'b0}};
            p_r     <= {PW{1'b0}};
            win_r   <= {PW{1'b0}};
            gnt     <= {N{1'b0}};
            done    <= {N{1'b0}};
            result  <= {CW{1'b0}};
            busy    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            a_r     <= a_next_s;
            b_r     <= b_next_s;
            p_r     <= p_next_s;
            win_r   <= win_next_s;
            gnt     <= gnt_next_s;
            done    <= done_next_s;
            result  <= result_next_s;
            busy    <= busy_next_s;
        end
    end

endmodule

// File: tb/tb_popcount_arbiter.sv
// -----------------------------------------------------------------------------
// tb_popcount_arbiter
//
// Directed bench for popcount_arbiter (W=8, N=4). Inputs change and outputs are
// sampled 1 time unit after each rising edge. Expected values are computed by
// hand from the words applied.
// -----------------------------------------------------------------------------
module tb_popcount_arbiter;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int CW = 4;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*W-1:0]  data_in;
    logic [N-1:0]    gnt;
    logic            busy;
    logic [N-1:0]    done;
    logic [CW-1:0]   result;

    int errors;
    int checks;

    popcount_arbiter #(.W(W), .N(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .data_in (data_in),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Advance until done is seen or the bound runs out; captures the outputs.
    task automatic wait_done(input int bound, output logic [N-1:0] g,
                             output logic [N-1:0] d, output logic [CW-1:0] r,
                             output int cyc, output bit seen);
        seen = 1'b0;
        cyc  = 0;
        g    = '0;
        d    = '0;
        r    = '0;
        while (!seen && cyc < bound) begin
            if (done != 4'b0000) begin
                seen = 1'b1;
                g    = gnt;
                d    = done;
                r    = result;
            end else begin
                tick();
                cyc++;
            end
        end
    endtask

    task automatic test_reset;
        reset   = 1'b1;
        req     = 4'b0000;
        data_in = 32'h0000_0000;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if ({gnt, done, busy, result} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b done=%b busy=%b result=%0d, expected all zero",
                     gnt, done, busy, result);
        end
        tick();
        checks++;
        if ({gnt, done, busy} !== 9'd0) begin
            errors++;
            $display("FAIL idle_no_req: gnt=%b done=%b busy=%b, expected all zero", gnt, done, busy);
        end
    endtask

    // Word B5: 8 shifts plus one zero-detect cycle, then DONE -> 10 grant cycles.
    task automatic test_single_b5;
        int gcnt;
        int dcnt;
        int dcyc;
        int c;
        req            = 4'b0001;
        data_in[7:0]   = 8'hB5;
        tick();
        req  = 4'b0000;
        gcnt = 0;
        dcnt = 0;
        dcyc = -1;
        c    = 0;
        while (c < 40 && !(gnt == 4'b0000 && c > 0)) begin
            if (gnt == 4'b0001) gcnt++;
            if (done != 4'b0000) begin
                dcnt++;
                dcyc = c;
                checks++;
                if (done !== 4'b0001 || gnt !== 4'b0001 || result !== 4'd5) begin
                    errors++;
                    $display("FAIL b5_done: done=%b gnt=%b result=%0d, expected 0001 0001 5",
                             done, gnt, result);
                end
            end
            tick();
            c++;
        end
        checks++;
        if (gcnt !== 10) begin
            errors++;
            $display("FAIL b5_gnt_len: got %0d cycles, expected 10", gcnt);
        end
        checks++;
        if (dcnt !== 1 || dcyc !== 9) begin
            errors++;
            $display("FAIL b5_done_pulse: count=%0d at cycle %0d, expected 1 at cycle 9", dcnt, dcyc);
        end
        checks++;
        if (busy !== 1'b0 || result !== 4'd5) begin
            errors++;
            $display("FAIL b5_after: busy=%b result=%0d, expected 0 and 5 held", busy, result);
        end
    endtask

    task automatic test_zero_word;
        req          = 4'b0001;
        data_in[7:0] = 8'h00;
        tick();
        req = 4'b0000;
        checks++;
        if (busy !== 1'b1 || gnt !== 4'b0001 || done !== 4'b0000) begin
            errors++;
            $display("FAIL zero_shift: busy=%b gnt=%b done=%b, expected 1 0001 0000", busy, gnt, done);
        end
        tick();
        checks++;
        if (done !== 4'b0001 || result !== 4'd0) begin
            errors++;
            $display("FAIL zero_done: done=%b result=%0d, expected 0001 0", done, result);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || gnt !== 4'b0000 || done !== 4'b0000) begin
            errors++;
            $display("FAIL zero_idle: busy=%b gnt=%b done=%b, expected 0 0000 0000", busy, gnt, done);
        end
    endtask

    task automatic test_round_robin;
        logic [N-1:0]  g;
        logic [N-1:0]  d;
        logic [CW-1:0] r;
        int            cyc;
        bit            seen;
        logic [CW-1:0] exp_r [4];
        exp_r[0] = 4'd8;
        exp_r[1] = 4'd1;
        exp_r[2] = 4'd4;
        exp_r[3] = 4'd1;
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        data_in = 32'h800F_01FF;
        req     = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wait_done(40, g, d, r, cyc, seen);
            checks++;
            if (!seen || g !== (4'b0001 << i) || d !== g || r !== exp_r[i]) begin
                errors++;
                $display("FAIL rr_serve%0d: seen=%b gnt=%b done=%b result=%0d, expected gnt=done=%b result=%0d",
                         i, seen, g, d, r, 4'b0001 << i, exp_r[i]);
            end
            tick();
        end
        req = 4'b0000;
        tick();
        tick();

        // Serve requester 1 alone so the pointer moves to 2.
        req = 4'b0010;
        wait_done(40, g, d, r, cyc, seen);
        checks++;
        if (!seen || g !== 4'b0010 || r !== 4'd1) begin
            errors++;
            $display("FAIL ptr_serve1: seen=%b gnt=%b result=%0d, expected 0010 1", seen, g, r);
        end
        req = 4'b0011;
        tick();
        wait_done(40, g, d, r, cyc, seen);
        checks++;
        if (!seen || g !== 4'b0001 || r !== 4'd8) begin
            errors++;
            $display("FAIL ptr_wrap0: seen=%b gnt=%b result=%0d, expected 0001 8", seen, g, r);
        end
        tick();
        wait_done(40, g, d, r, cyc, seen);
        checks++;
        if (!seen || g !== 4'b0010 || r !== 4'd1) begin
            errors++;
            $display("FAIL ptr_then1: seen=%b gnt=%b result=%0d, expected 0010 1", seen, g, r);
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_reset_mid;
        logic [N-1:0]  g;
        logic [N-1:0]  d;
        logic [CW-1:0] r;
        int            cyc;
        bit            seen;
        bit            stray;
        req          = 4'b0001;
        data_in[7:0] = 8'hFF;
        tick();
        req = 4'b0000;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({gnt, done, busy, result} !== 13'd0) begin
            errors++;
            $display("FAIL mid_reset: gnt=%b done=%b busy=%b result=%0d, expected all zero",
                     gnt, done, busy, result);
        end
        stray = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done != 4'b0000 || busy != 1'b0) stray = 1'b1;
            tick();
        end
        checks++;
        if (stray !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_quiet: activity=%b after abort, expected 0", stray);
        end
        req            = 4'b0100;
        data_in[23:16] = 8'h3C;
        wait_done(40, g, d, r, cyc, seen);
        checks++;
        if (!seen || g !== 4'b0100 || d !== 4'b0100 || r !== 4'd4) begin
            errors++;
            $display("FAIL after_reset2: seen=%b gnt=%b done=%b result=%0d, expected 0100 0100 4",
                     seen, g, d, r);
        end
        req = 4'b0000;
        tick();
        tick();

        // Pointer is 3 here; after reset it must restart at 0.
        reset = 1'b1;
        tick();
        reset          = 1'b0;
        data_in[7:0]   = 8'h03;
        data_in[31:24] = 8'h07;
        req            = 4'b1001;
        wait_done(40, g, d, r, cyc, seen);
        checks++;
        if (!seen || g !== 4'b0001 || r !== 4'd2) begin
            errors++;
            $display("FAIL ptr_reset: seen=%b gnt=%b result=%0d, expected 0001 2", seen, g, r);
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_drop_and_change;
        logic [N-1:0]  g;
        logic [N-1:0]  d;
        logic [CW-1:0] r;
        int            cyc;
        bit            seen;
        req          = 4'b0001;
        data_in[7:0] = 8'h0F;
        tick();
        req          = 4'b0000;
        data_in[7:0] = 8'hFF;
        wait_done(40, g, d, r, cyc, seen);
        checks++;
        if (!seen || g !== 4'b0001 || d !== 4'b0001 || r !== 4'd4) begin
            errors++;
            $display("FAIL drop_change: seen=%b gnt=%b done=%b result=%0d, expected 0001 0001 4",
                     seen, g, d, r);
        end
        tick();
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single_b5();
        test_zero_word();
        test_round_robin();
        test_reset_mid();
        test_drop_and_change();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
